// File: rtl/i2f_share_arbiter.sv
// i2f_share_arbiter
// Time-shares one external combinational int32 -> float32 converter between
// NREQ requesters. A round-robin search picks one requester in IDLE. Its
// operand is registered onto conv_in and held for a CONV_LAT-cycle settle
// window. The converter output is then captured and presented with the owner's
// index until the consumer takes it.
module i2f_share_arbiter #(
  parameter int NREQ     = 2,
  parameter int IDW      = 3,
  parameter int CONV_LAT = 1,
  parameter int CNTW     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          conv_in,
  input  logic [31:0]          conv_out,
  output logic                 resp_valid,
  output logic [31:0]          resp_data,
  output logic [IDW-1:0]       resp_id,
  input  logic                 resp_ready,
  output logic                 busy,
  output logic [CNTW-1:0]      done_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LW = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [31:0]       op_q, op_d;
  logic [31:0]       res_q, res_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [CNTW-1:0]   done_q, done_d;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic              grant_any;
  logic [PW:0]       grant_sum;
  logic [PW-1:0]     grant_idx;
  logic              grant_en;
  logic [31:0]       grant_data;

  // Round-robin search: rotate the request vector so rr_q sits at bit 0, take
  // the lowest set bit, then map the offset back to an absolute index.
  always_comb begin
    req_dbl   = {req_valid, req_valid} >> rr_q;
    req_rot   = req_dbl[NREQ-1:0];
    grant_any = 1'b0;
    grant_sum = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_any && req_rot[k]) begin
        grant_any = 1'b1;
        grant_sum = {1'b0, rr_q} + (PW+1)'(k);
      end
    end
    if (grant_sum >= (PW+1)'(NREQ)) begin
      grant_sum = grant_sum - (PW+1)'(NREQ);
    end
    grant_idx = grant_sum[PW-1:0];
  end

  // One-hot grant and operand mux; the grant is suppressed outside IDLE and
  // while reset is asserted, so no handshake can complete during reset.
  always_comb begin
    grant_en   = rst_n && (state_q == S_IDLE) && grant_any;
    req_ready  = '0;
    grant_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == PW'(i)) begin
        req_ready[i] = grant_en;
        grant_data   = req_data[32*i +: 32];
      end
    end
  end

  // Next-state logic for the IDLE -> CONV -> RESP transaction sequence.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    op_d    = op_q;
    res_d   = res_q;
    id_d    = id_q;
    lat_d   = lat_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          op_d    = grant_data;
          id_d    = IDW'(grant_idx);
          rr_d    = (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + PW'(1);
          lat_d   = LW'(CONV_LAT-1);
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        // conv_out is only sampled once the settle window has elapsed.
        if (lat_q == '0) begin
          res_d   = conv_out;
          state_d = S_RESP;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      S_RESP: begin
        // Returning to IDLE means the next grant is at least one cycle later.
        if (resp_ready) begin
          done_d  = done_q + CNTW'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      op_q    <= '0;
      res_q   <= '0;
      id_q    <= '0;
      lat_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      op_q    <= op_d;
      res_q   <= res_d;
      id_q    <= id_d;
      lat_q   <= lat_d;
      done_q  <= done_d;
    end
  end

  assign conv_in    = op_q;
  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = res_q;
  assign resp_id    = id_q;
  assign busy       = (state_q != S_IDLE);
  assign done_cnt   = done_q;

endmodule

// File: tb/tb_i2f_share_arbiter.sv
// Bench for i2f_share_arbiter: three instances (default, CONV_LAT=3, CNTW=4),
// each wired to a behavioural int32 -> float32 converter.
module tb_i2f_share_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Instance 0: defaults
  logic [1:0]  rv0, rr0;
  logic [63:0] rd0;
  logic [31:0] ci0, co0, vd0;
  logic        vv0, vr0, by0;
  logic [2:0]  vid0;
  logic [15:0] dc0;
  // Instance 3: CONV_LAT=3
  logic [1:0]  rv3, rr3;
  logic [63:0] rd3;
  logic [31:0] ci3, co3, vd3;
  logic        vv3, vr3, by3;
  logic [2:0]  vid3;
  logic [15:0] dc3;
  // Instance 4: CNTW=4
  logic [1:0]  rv4, rr4;
  logic [63:0] rd4;
  logic [31:0] ci4, co4, vd4;
  logic        vv4, vr4, by4;
  logic [2:0]  vid4;
  logic [3:0]  dc4;

  // Converter: int32 -> IEEE-754 single, round to nearest even.
  function automatic logic [31:0] i2f(input logic [31:0] x);
    logic        sgn;
    logic [31:0] mag, m, rem, half;
    int          p, sh, e;
    if (x == 32'd0) return 32'd0;
    sgn = x[31];
    mag = sgn ? (~x + 32'd1) : x;
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
    e = 127 + p;
    if (p <= 23) begin
      m = mag << (23 - p);
    end else begin
      sh   = p - 23;
      m    = mag >> sh;
      rem  = mag & ((32'd1 << sh) - 32'd1);
      half = 32'd1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 32'd1;
      if (m[24]) begin
        m = m >> 1;
        e = e + 1;
      end
    end
    return {sgn, e[7:0], m[22:0]};
  endfunction

  assign co0 = i2f(ci0);
  assign co3 = i2f(ci3);
  assign co4 = i2f(ci4);

  i2f_share_arbiter #(.NREQ(2), .IDW(3), .CONV_LAT(1), .CNTW(16)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_data(rd0), .req_ready(rr0),
    .conv_in(ci0), .conv_out(co0), .resp_valid(vv0), .resp_data(vd0), .resp_id(vid0),
    .resp_ready(vr0), .busy(by0), .done_cnt(dc0));

  i2f_share_arbiter #(.NREQ(2), .IDW(3), .CONV_LAT(3), .CNTW(16)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv3), .req_data(rd3), .req_ready(rr3),
    .conv_in(ci3), .conv_out(co3), .resp_valid(vv3), .resp_data(vd3), .resp_id(vid3),
    .resp_ready(vr3), .busy(by3), .done_cnt(dc3));

  i2f_share_arbiter #(.NREQ(2), .IDW(3), .CONV_LAT(1), .CNTW(4)) u4 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv4), .req_data(rd4), .req_ready(rr4),
    .conv_in(ci4), .conv_out(co4), .resp_valid(vv4), .resp_data(vd4), .resp_id(vid4),
    .resp_ready(vr4), .busy(by4), .done_cnt(dc4));

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rv0 = '0; rd0 = '0; vr0 = 1'b0;
    rv3 = '0; rd3 = '0; vr3 = 1'b0;
    rv4 = '0; rd4 = '0; vr4 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rv0 = 2'b11; rd0 = {32'h8000_0000, 32'h0000_0001}; vr0 = 1'b1;
    rv3 = 2'b11; rd3 = 64'h5;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (rr0 !== 2'b00) begin n_bad++; $display("FAIL rst_req_ready: got %b want 00", rr0); end
    n_vec++; if (rr3 !== 2'b00) begin n_bad++; $display("FAIL rst_req_ready_lat3: got %b want 00", rr3); end
    n_vec++; if (vv0 !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b want 0", vv0); end
    n_vec++; if (by0 !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", by0); end
    n_vec++; if (ci0 !== 32'h0) begin n_bad++; $display("FAIL rst_conv_in: got %h want 0", ci0); end
    n_vec++; if (vd0 !== 32'h0) begin n_bad++; $display("FAIL rst_resp_data: got %h want 0", vd0); end
    n_vec++; if (vid0 !== 3'd0) begin n_bad++; $display("FAIL rst_resp_id: got %0d want 0", vid0); end
    n_vec++; if (dc0 !== 16'd0) begin n_bad++; $display("FAIL rst_done_cnt: got %0d want 0", dc0); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++; if (rr0 !== 2'b01) begin n_bad++; $display("FAIL rst_first_grant: got %b want 01", rr0); end
  endtask

  task automatic test_single();
    do_reset();
    rv0 = 2'b01; rd0 = 64'h1; vr0 = 1'b1;
    #1;
    n_vec++; if (rr0 !== 2'b01) begin n_bad++; $display("FAIL single_grant: got %b want 01", rr0); end
    @(negedge clk);
    rv0 = 2'b00;
    #1;
    n_vec++; if (vv0 !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: got %b want 0", vv0); end
    n_vec++; if (by0 !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", by0); end
    n_vec++; if (ci0 !== 32'h1) begin n_bad++; $display("FAIL single_conv_in: got %h want 00000001", ci0); end
    @(negedge clk);
    #1;
    n_vec++; if (vv0 !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", vv0); end
    n_vec++; if (vd0 !== 32'h3F80_0000) begin n_bad++; $display("FAIL single_data: got %h want 3f800000", vd0); end
    n_vec++; if (vid0 !== 3'd0) begin n_bad++; $display("FAIL single_id: got %0d want 0", vid0); end
    @(negedge clk);
    #1;
    n_vec++; if (dc0 !== 16'd1) begin n_bad++; $display("FAIL single_done_cnt: got %0d want 1", dc0); end
    n_vec++; if (vv0 !== 1'b0) begin n_bad++; $display("FAIL single_valid_drop: got %b want 0", vv0); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_d [2];
    logic [1:0]  g;
    int          got;
    exp_d[0] = 32'hBF80_0000;
    exp_d[1] = 32'hCF00_0000;
    do_reset();
    rd0 = {32'h8000_0000, 32'hFFFF_FFFF};
    vr0 = 1'b1;
    for (int ph = 0; ph < 2; ph++) begin
      rv0 = 2'b11;
      got = 0;
      for (int c = 0; c < 40 && got < 2; c++) begin
        @(negedge clk);
        #1;
        if (vv0) begin
          n_vec++; if (vid0 !== 3'(got)) begin n_bad++; $display("FAIL rr_order ph%0d: got id %0d want %0d", ph, vid0, got); end
          n_vec++; if (vd0 !== exp_d[got]) begin n_bad++; $display("FAIL rr_data ph%0d: got %h want %h", ph, vd0, exp_d[got]); end
          got++;
        end
        if (rr0 != 2'b00) begin
          g = rr0;
          @(posedge clk);
          #1;
          rv0 = rv0 & ~g;
        end
      end
      n_vec++; if (got != 2) begin n_bad++; $display("FAIL rr_timeout ph%0d: got %0d responses want 2", ph, got); end
    end
  endtask

  task automatic test_backpressure();
    logic seen;
    do_reset();
    rv0 = 2'b01; rd0 = 64'h55; vr0 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (rr0 == 2'b01) seen = 1'b1;
    end
    n_vec++; if (!seen) begin n_bad++; $display("FAIL bp_grant: got %b want 01", rr0); end
    @(posedge clk);
    #1;
    rv0 = 2'b11; rd0 = {32'h77, 32'h66};
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (vv0) seen = 1'b1;
    end
    n_vec++; if (!seen) begin n_bad++; $display("FAIL bp_valid_timeout: got %b want 1", vv0); end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      n_vec++; if (vv0 !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid c%0d: got %b want 1", c, vv0); end
      n_vec++; if (vd0 !== i2f(32'h55)) begin n_bad++; $display("FAIL bp_hold_data c%0d: got %h want %h", c, vd0, i2f(32'h55)); end
      n_vec++; if (vid0 !== 3'd0) begin n_bad++; $display("FAIL bp_hold_id c%0d: got %0d want 0", c, vid0); end
      n_vec++; if (rr0 !== 2'b00) begin n_bad++; $display("FAIL bp_hold_ready c%0d: got %b want 00", c, rr0); end
    end
    @(negedge clk);
    vr0 = 1'b1;
    #1;
    n_vec++; if (rr0 !== 2'b00) begin n_bad++; $display("FAIL bp_accept_ready: got %b want 00", rr0); end
    @(negedge clk);
    vr0 = 1'b0;
    #1;
    n_vec++; if (rr0 !== 2'b10) begin n_bad++; $display("FAIL bp_next_grant: got %b want 10", rr0); end
  endtask

  task automatic test_abort();
    do_reset();
    rv0 = 2'b01; rd0 = 64'h1234; vr0 = 1'b1;
    #1;
    n_vec++; if (rr0 !== 2'b01) begin n_bad++; $display("FAIL abort_grant: got %b want 01", rr0); end
    @(posedge clk);
    #1;
    rv0 = 2'b11;
    rst_n = 1'b0;
    #1;
    n_vec++; if (rr0 !== 2'b00) begin n_bad++; $display("FAIL abort_ready: got %b want 00", rr0); end
    n_vec++; if (by0 !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b want 0", by0); end
    n_vec++; if (ci0 !== 32'h0) begin n_bad++; $display("FAIL abort_conv_in: got %h want 0", ci0); end
    n_vec++; if (vv0 !== 1'b0) begin n_bad++; $display("FAIL abort_valid: got %b want 0", vv0); end
    @(negedge clk);
    rst_n = 1'b1;
    rv0 = 2'b00;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_vec++; if (vv0 !== 1'b0) begin n_bad++; $display("FAIL abort_no_resp c%0d: got %b want 0", c, vv0); end
      n_vec++; if (dc0 !== 16'd0) begin n_bad++; $display("FAIL abort_done_cnt c%0d: got %0d want 0", c, dc0); end
      @(negedge clk);
    end
    rv0 = 2'b11;
    #1;
    n_vec++; if (rr0 !== 2'b01) begin n_bad++; $display("FAIL abort_rr_ptr: got %b want 01", rr0); end
  endtask

  task automatic test_latency3();
    logic [31:0] ops [2];
    logic [1:0]  who [2];
    logic        seen;
    ops[0] = 32'h0; ops[1] = 32'h1234_5678;
    who[0] = 2'b10; who[1] = 2'b01;
    do_reset();
    vr3 = 1'b1;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) begin
        rv3 = 2'b10; rd3 = {ops[0], 32'hAAAA_AAAA};
      end else begin
        rv3 = 2'b01; rd3 = {32'hBBBB_BBBB, ops[1]};
      end
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        if (c > 0) @(negedge clk);
        #1;
        if (rr3 != 2'b00) seen = 1'b1;
      end
      n_vec++; if (rr3 !== who[t]) begin n_bad++; $display("FAIL lat3_grant t%0d: got %b want %b", t, rr3, who[t]); end
      @(posedge clk);
      #1;
      rv3 = 2'b00; rd3 = 64'hDEAD_BEEF_CAFE_F00D;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        #1;
        if (k < 4) begin
          n_vec++; if (vv3 !== 1'b0) begin n_bad++; $display("FAIL lat3_early t%0d k%0d: got %b want 0", t, k, vv3); end
          n_vec++; if (ci3 !== ops[t]) begin n_bad++; $display("FAIL lat3_conv_in t%0d k%0d: got %h want %h", t, k, ci3, ops[t]); end
        end else begin
          n_vec++; if (vv3 !== 1'b1) begin n_bad++; $display("FAIL lat3_valid t%0d: got %b want 1", t, vv3); end
          n_vec++; if (vd3 !== i2f(ops[t])) begin n_bad++; $display("FAIL lat3_data t%0d: got %h want %h", t, vd3, i2f(ops[t])); end
          n_vec++; if (vid3 !== ((t == 0) ? 3'd1 : 3'd0)) begin n_bad++; $display("FAIL lat3_id t%0d: got %0d want %0d", t, vid3, (t == 0) ? 1 : 0); end
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    int acc;
    do_reset();
    rd4 = {32'h3, 32'h3}; rv4 = 2'b01; vr4 = 1'b1;
    acc = 0;
    for (int c = 0; c < 100 && acc < 17; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_vec++; if (dc4 !== 4'(acc)) begin n_bad++; $display("FAIL wrap_done_cnt c%0d: got %0d want %0d", c, dc4, acc % 16); end
      if (vv4) begin
        n_vec++; if (vd4 !== 32'h4040_0000) begin n_bad++; $display("FAIL wrap_data n%0d: got %h want 40400000", acc, vd4); end
        acc++;
        if (acc == 17) rv4 = 2'b00;
      end
    end
    n_vec++; if (acc != 17) begin n_bad++; $display("FAIL wrap_timeout: got %0d conversions want 17", acc); end
    @(negedge clk);
    #1;
    n_vec++; if (dc4 !== 4'd1) begin n_bad++; $display("FAIL wrap_final: got %0d want 1", dc4); end
    n_vec++; if (by4 !== 1'b0) begin n_bad++; $display("FAIL wrap_idle: got %b want 0", by4); end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Reference: pending requests per requester, one transaction in flight,
  // response due CONV_LAT+1 cycles after its grant, winner by cyclic search.
  task automatic test_random();
    bit          pend [2];
    logic [31:0] pdat [2];
    int          rrm, gcyc, gid, done_m, w, idx;
    bit          infl, exp_vld;
    logic [1:0]  exp_rdy;
    logic [31:0] gdat;
    do_reset();
    pend[0] = 0; pend[1] = 0; pdat[0] = '0; pdat[1] = '0;
    rrm = 0; infl = 0; done_m = 0; gcyc = 0; gid = 0; gdat = '0; w = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc > 0) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1;
          pdat[i] = pick_operand();
        end
      end
      rv0 = {pend[1], pend[0]};
      rd0 = {pdat[1], pdat[0]};
      vr0 = 1'($urandom_range(1));
      #1;
      exp_rdy = 2'b00;
      if (!infl) begin
        for (int k = 0; k < 2; k++) begin
          idx = (rrm + k) % 2;
          if (pend[idx] && exp_rdy == 2'b00) begin
            exp_rdy[idx] = 1'b1;
            w = idx;
          end
        end
      end
      exp_vld = infl && (cyc >= gcyc + 2);
      n_vec++; if (rr0 !== exp_rdy) begin n_bad++; $display("FAIL rnd_ready cyc%0d: got %b want %b", cyc, rr0, exp_rdy); end
      n_vec++; if (vv0 !== exp_vld) begin n_bad++; $display("FAIL rnd_valid cyc%0d: got %b want %b", cyc, vv0, exp_vld); end
      n_vec++; if (by0 !== infl) begin n_bad++; $display("FAIL rnd_busy cyc%0d: got %b want %b", cyc, by0, infl); end
      n_vec++; if (dc0 !== 16'(done_m)) begin n_bad++; $display("FAIL rnd_done_cnt cyc%0d: got %0d want %0d", cyc, dc0, done_m); end
      if (infl) begin
        n_vec++; if (ci0 !== gdat) begin n_bad++; $display("FAIL rnd_conv_in cyc%0d: got %h want %h", cyc, ci0, gdat); end
      end
      if (exp_vld) begin
        n_vec++; if (vd0 !== i2f(gdat)) begin n_bad++; $display("FAIL rnd_data cyc%0d: got %h want %h", cyc, vd0, i2f(gdat)); end
        n_vec++; if (vid0 !== 3'(gid)) begin n_bad++; $display("FAIL rnd_id cyc%0d: got %0d want %0d", cyc, vid0, gid); end
        if (vr0) begin
          infl = 0;
          done_m++;
        end
      end
      if (exp_rdy != 2'b00) begin
        infl = 1;
        gcyc = cyc;
        gid  = w;
        gdat = pdat[w];
        pend[w] = 0;
        rrm = (w + 1) % 2;
      end
    end
  endtask

  initial begin
    rv0 = '0; rd0 = '0; vr0 = 1'b0;
    rv3 = '0; rd3 = '0; vr3 = 1'b0;
    rv4 = '0; rd4 = '0; vr4 = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_abort();
    test_latency3();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
